// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings for
// memory operations and the sequencing state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    WRITE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane helper for the load/store unit (purely combinational).
// Ports:
//   word      - 32-bit word read from data_memory
//   offset    - byte offset within the word (addr[1:0])
//   funct3    - RV32I memory funct3
//   wdata     - store data (low byte/halfword used for SB/SH)
//   load_data - extracted and sign/zero-extended load result
//   merged    - word with the addressed lane replaced by store data
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word[7:0];
    case (offset)
      2'd0: lane_byte = word[7:0];
      2'd1: lane_byte = word[15:8];
      2'd2: lane_byte = word[23:16];
      2'd3: lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
    lane_half = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_BU:   load_data = {24'd0, lane_byte};
      F3_HU:   load_data = {16'd0, lane_half};
      default: load_data = word;
    endcase

    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = word;
        case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H:    merged = offset[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-only data_memory.
// Loads complete in one cycle; SW writes directly; SB/SH do read-modify-write.
// Ports:
//   clk, reset_n              - clock, synchronous active-low reset
//   req_valid/ready/write     - request handshake and direction
//   req_funct3/addr/wdata     - RV32I funct3, byte address, store data
//   resp_valid/rdata/error    - registered one-cycle completion
//   mem_address/write_data/write_enable, mem_read_data - data_memory side
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * WORDS);

  lsu_state_t  state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;

  logic        accept;
  logic        bad_f3;
  logic        req_err;
  logic [1:0]  lane_off;
  logic [2:0]  lane_f3;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Alignment terms are only meaningful for legal funct3 values; an
  // illegal funct3 already forces the error, so precedence is moot.
  always_comb begin
    if (req_write) bad_f3 = (req_funct3 > F3_W);
    else           bad_f3 = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    req_err = bad_f3
           || ({1'b0, req_addr} >= ADDR_LIMIT)
           || ((req_funct3[1:0] == 2'b01) && req_addr[0])
           || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // One lane helper serves both the IDLE load path and the MERGE step.
  assign lane_off = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign lane_f3  = (state == IDLE) ? req_funct3    : funct3_q;

  lsu_lane u_lane (
    .word      (mem_read_data),
    .offset    (lane_off),
    .funct3    (lane_f3),
    .wdata     (wdata_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  assign mem_address      = (state == IDLE) ? {req_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
  assign mem_write_enable = (state == WRITE) && reset_n;
  assign mem_write_data   = (state != WRITE) ? 32'd0
                          : (funct3_q == F3_W) ? wdata_q : merged_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
      addr_q     <= 32'd0;
      funct3_q   <= 3'd0;
      wdata_q    <= 32'd0;
      merged_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (!req_write) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= lane_load;
            end else begin
              addr_q   <= req_addr;
              funct3_q <= req_funct3;
              wdata_q  <= req_wdata;
              state    <= (req_funct3 == F3_W) ? WRITE : MERGE;
            end
          end
        end
        MERGE: begin
          merged_q <= lane_merged;
          state    <= WRITE;
        end
        WRITE: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests checked against an array-based reference of data_memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  int total = 0;
  int bad   = 0;

  // data_memory stand-in (environment) and the reference image (model)
  logic [31:0] bmem [64];
  logic [31:0] model_mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  load_store_unit #(.WORDS(64)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always_comb begin
    mem_read_data = 32'd0;
    if (mem_address < 32'd256) mem_read_data = bmem[mem_address[7:2]];
  end

  always @(posedge clk) begin
    if (pl_en) bmem[pl_idx] <= pl_data;
    else if (mem_write_enable && mem_address < 32'd256) bmem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit ref_err(bit wr, logic [2:0] f3, logic [31:0] a);
    bit legal;
    int size;
    legal = wr ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size  = 1 << (f3 % 4);
    return !legal || a >= 32'd256 || (a % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] w, v;
    int sh;
    w  = model_mem[a / 4];
    sh = (a % 4) * 8;
    case (f3)
      3'd0: begin v = (w >> sh) & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
      3'd1: begin v = (w >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
      3'd4: v = (w >> sh) & 32'hFF;
      3'd5: v = (w >> sh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] a, logic [2:0] f3, logic [31:0] wd);
    logic [31:0] w, mask;
    int sh;
    if (f3 == 3'd2) return wd;
    w    = model_mem[a / 4];
    sh   = (a % 4) * 8;
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issue one request from an IDLE cycle and check every cycle up to and
  // including its response cycle; returns with the response still visible.
  task automatic do_op(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] got);
    bit err;
    int lat, n;
    logic [31:0] exp_rd, exp_word;
    err      = ref_err(wr, f3, a);
    exp_rd   = (err || wr) ? 32'd0 : ref_load(a, f3);
    exp_word = (wr && !err) ? ref_store(a, f3, wd) : 32'd0;
    lat      = err || !wr ? 1 : (f3 == 3'd2 ? 2 : 3);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick; n++; end
    chk("acc_rdy", req_ready, 1);
    tick;
    req_valid = 1'b0;
    got = 32'd0;
    for (int k = 1; k <= lat; k++) begin
      chk("we", mem_write_enable, (wr && !err && k == lat - 1));
      if (wr && !err && k == lat - 1) begin
        chk("wdata", mem_write_data, exp_word);
        chk("waddr", mem_address, a & ~32'd3);
      end
      chk("rv", resp_valid, (k == lat));
      chk("rdy", req_ready, (k == lat));
      if (k == lat) begin
        chk("rerr", resp_error, err);
        chk("rdata", resp_rdata, exp_rd);
        got = resp_rdata;
      end else begin
        tick;
      end
    end
    if (wr && !err) model_mem[a / 4] = exp_word;
  endtask

  initial begin
    logic [31:0] got, a, wd;
    logic [2:0]  f3;
    bit          wr;
    int          r;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; pl_en = 1'b1; pl_idx = 6'd0; pl_data = 32'd0;
    #1;
    for (int i = 0; i < 64; i++) begin
      pl_idx  = 6'(i);
      pl_data = (i == 4) ? 32'h8899AABB : $urandom;
      model_mem[i] = pl_data;
      tick;
    end
    pl_en = 1'b0;
    chk("rst_rv", resp_valid, 0);
    chk("rst_we", mem_write_enable, 0);
    reset_n = 1'b1;
    chk("rst_rdy", req_ready, 1);
    chk("rst_rerr", resp_error, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_wd", mem_write_data, 0);

    // back-to-back loads from the preloaded word
    do_op(0, 3'd0, 32'h11, 0, got); chk("lb_c",  got, 32'hFFFFFFAA);
    do_op(0, 3'd4, 32'h13, 0, got); chk("lbu_c", got, 32'h00000088);
    do_op(0, 3'd1, 32'h12, 0, got); chk("lh_c",  got, 32'hFFFF8899);
    do_op(0, 3'd5, 32'h10, 0, got); chk("lhu_c", got, 32'h0000AABB);
    do_op(0, 3'd2, 32'h10, 0, got); chk("lw_c",  got, 32'h8899AABB);

    do_op(1, 3'd0, 32'h11, 32'h12345677, got);
    do_op(0, 3'd2, 32'h10, 0, got); chk("sb_c", got, 32'h889977BB);
    do_op(1, 3'd2, 32'h20, 32'hDEADBEEF, got);
    do_op(1, 3'd1, 32'h22, 32'h0000CAFE, got);
    do_op(0, 3'd2, 32'h20, 0, got); chk("sh_c", got, 32'hCAFEBEEF);

    do_op(1, 3'd1, 32'h13, 32'h1, got);  chk("e_sh",  resp_error, 1);
    do_op(0, 3'd2, 32'h06, 0, got);      chk("e_lw",  resp_error, 1);
    do_op(1, 3'd2, 32'h100, 32'h1, got); chk("e_rng", resp_error, 1);
    do_op(0, 3'd3, 32'h00, 0, got);      chk("e_f3",  resp_error, 1);

    // reset while the SB sits in MERGE aborts it
    req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h55; req_valid = 1'b1;
    chk("ab_acc", req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk("ab_m_rdy", req_ready, 0);
    reset_n = 1'b0;
    chk("ab_m_we", mem_write_enable, 0);
    tick;
    reset_n = 1'b1;
    chk("ab_rdy", req_ready, 1);
    chk("ab_rv1", resp_valid, 0);
    chk("ab_we1", mem_write_enable, 0);
    tick;
    chk("ab_rv2", resp_valid, 0);
    chk("ab_we2", mem_write_enable, 0);
    chk("ab_mem", bmem[8], model_mem[8]);

    // LB held high through an SB's MERGE/WRITE
    wd = $urandom;
    req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h12; req_wdata = wd; req_valid = 1'b1;
    chk("h_acc", req_ready, 1);
    model_mem[4] = ref_store(32'h12, 3'd0, wd);
    tick;
    req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h12;
    chk("h_rdy1", req_ready, 0);
    chk("h_rv1", resp_valid, 0);
    tick;
    chk("h_rdy2", req_ready, 0);
    chk("h_we2", mem_write_enable, 1);
    chk("h_wd2", mem_write_data, model_mem[4]);
    tick;
    chk("h_rv3", resp_valid, 1);
    chk("h_rdy3", req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk("h_rv4", resp_valid, 1);
    chk("h_rd4", resp_rdata, ref_load(32'h12, 3'd0));
    tick;
    chk("h_rv5", resp_valid, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        r  = $urandom_range(0, wr ? 2 : 4);
        f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'd256 + $urandom_range(0, 63);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 255);
      if (!ref_err(wr, f3, a) && $urandom_range(0, 1) == 1) a = a & ~32'd3;
      do_op(wr, f3, a, $urandom, got);
    end

    tick;
    for (int i = 0; i < 64; i++) chk("mem", bmem[i], model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
